// File: rtl/morse_encoder_az.sv
// morse_encoder_az: latches a letter A-Z and serialises its Morse pattern, one symbol per SYMBOL_CYCLES clocks.
// Define MORSE_REPEAT_EN to honour Repeat and loop the letter with GAP_SYMBOLS off-symbols in between.
module morse_encoder_az #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int SYMBOL_DIV      = 2,
    parameter int GAP_SYMBOLS     = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
    input  logic       Repeat,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);
    localparam int SC = CLOCK_FREQUENCY / SYMBOL_DIV;
    localparam int DW = SC > 1 ? $clog2(SC) : 1;
    localparam logic [DW-1:0] RELOAD = DW'(SC - 1);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   sh_q, sh_d;
    logic [3:0]    len_q, len_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          nb_q, nb_d, done_q, done_d, err_q, err_d;
    logic [15:0]   rom_raw, rom_pat;
    logic [3:0]    rom_len;
`ifdef MORSE_REPEAT_EN
    localparam int GW = GAP_SYMBOLS > 1 ? $clog2(GAP_SYMBOLS) : 1;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   pat_q, pat_d;
    logic [3:0]    plen_q, plen_d;
`else
    logic unused_repeat;
    assign unused_repeat = Repeat;
`endif

    // Patterns are stored right-aligned here and left-justified so bit 15 is the first symbol.
    always_comb begin
        {rom_len, rom_raw} = {4'd0, 16'd0};
        case (Letter)
            5'd0:  {rom_len, rom_raw} = {4'd5,  16'b10111};
            5'd1:  {rom_len, rom_raw} = {4'd9,  16'b111010101};
            5'd2:  {rom_len, rom_raw} = {4'd11, 16'b11101011101};
            5'd3:  {rom_len, rom_raw} = {4'd7,  16'b1110101};
            5'd4:  {rom_len, rom_raw} = {4'd1,  16'b1};
            5'd5:  {rom_len, rom_raw} = {4'd9,  16'b101011101};
            5'd6:  {rom_len, rom_raw} = {4'd9,  16'b111011101};
            5'd7:  {rom_len, rom_raw} = {4'd7,  16'b1010101};
            5'd8:  {rom_len, rom_raw} = {4'd3,  16'b101};
            5'd9:  {rom_len, rom_raw} = {4'd13, 16'b1011101110111};
            5'd10: {rom_len, rom_raw} = {4'd9,  16'b111010111};
            5'd11: {rom_len, rom_raw} = {4'd9,  16'b101110101};
            5'd12: {rom_len, rom_raw} = {4'd7,  16'b1110111};
            5'd13: {rom_len, rom_raw} = {4'd5,  16'b11101};
            5'd14: {rom_len, rom_raw} = {4'd11, 16'b11101110111};
            5'd15: {rom_len, rom_raw} = {4'd11, 16'b10111011101};
            5'd16: {rom_len, rom_raw} = {4'd13, 16'b1110111010111};
            5'd17: {rom_len, rom_raw} = {4'd7,  16'b1011101};
            5'd18: {rom_len, rom_raw} = {4'd5,  16'b10101};
            5'd19: {rom_len, rom_raw} = {4'd3,  16'b111};
            5'd20: {rom_len, rom_raw} = {4'd7,  16'b1010111};
            5'd21: {rom_len, rom_raw} = {4'd9,  16'b101010111};
            5'd22: {rom_len, rom_raw} = {4'd9,  16'b101110111};
            5'd23: {rom_len, rom_raw} = {4'd11, 16'b11101010111};
            5'd24: {rom_len, rom_raw} = {4'd13, 16'b1110101110111};
            5'd25: {rom_len, rom_raw} = {4'd11, 16'b11101110101};
            default: {rom_len, rom_raw} = {4'd0, 16'd0};
        endcase
        rom_pat = rom_raw << (5'd16 - {1'b0, rom_len});
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        nb_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MORSE_REPEAT_EN
        gap_d   = gap_q;
        pat_d   = pat_q;
        plen_d  = plen_q;
`endif
        case (state_q)
            IDLE: begin
                err_d = Start && Letter > 5'd25;
                if (Start && Letter <= 5'd25) begin
                    state_d = SEND;
                    sh_d    = rom_pat;
                    len_d   = rom_len;
                    cnt_d   = RELOAD;
                    nb_d    = 1'b1;
`ifdef MORSE_REPEAT_EN
                    pat_d   = rom_pat;
                    plen_d  = rom_len;
`endif
                end
            end
            SEND: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    cnt_d = RELOAD;
                    if (len_q > 4'd1) begin
                        sh_d  = sh_q << 1;
                        len_d = len_q - 4'd1;
                        nb_d  = 1'b1;
                    end
`ifdef MORSE_REPEAT_EN
                    else if (Repeat) begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_SYMBOLS - 1);
                        sh_d    = '0;
                        len_d   = '0;
                        nb_d    = 1'b1;
                    end
`endif
                    else begin
                        state_d = IDLE;
                        sh_d    = '0;
                        len_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef MORSE_REPEAT_EN
            GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    cnt_d = RELOAD;
                    nb_d  = 1'b1;
                    if (gap_q == '0) begin
                        state_d = SEND;
                        sh_d    = pat_q;
                        len_d   = plen_q;
                    end else gap_d = gap_q - 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            nb_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MORSE_REPEAT_EN
            gap_q   <= '0;
            pat_q   <= '0;
            plen_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MORSE_REPEAT_EN
            gap_q   <= gap_d;
            pat_q   <= pat_d;
            plen_q  <= plen_d;
`endif
        end
    end

    assign Busy       = state_q != IDLE;
    assign DotDashOut = state_q == SEND && sh_q[15];
    assign NewBitOut  = nb_q;
    assign Done       = done_q;
    assign Error      = err_q;
endmodule

// File: tb/tb_morse_encoder_az.sv
// tb_morse_encoder_az: checks two encoders (4 and 1 cycles per symbol) against a Morse-string model.
module tb_morse_encoder_az;
    logic ClockIn = 1'b0, Reset = 1'b1, Start = 1'b0, Repeat = 1'b0;
    logic [4:0] Letter = 5'd0;
    logic dd4, nb4, busy4, done4, err4, dd1, nb1, busy1, done1, err1;
    int n_cmp = 0, n_bad = 0;
`ifdef MORSE_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam int GAPS = 3;

    always #5 ClockIn = ~ClockIn;

    morse_encoder_az #(.CLOCK_FREQUENCY(8), .SYMBOL_DIV(2), .GAP_SYMBOLS(GAPS)) u4 (
        .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Letter(Letter), .Repeat(Repeat),
        .DotDashOut(dd4), .NewBitOut(nb4), .Busy(busy4), .Done(done4), .Error(err4));
    morse_encoder_az #(.CLOCK_FREQUENCY(3), .SYMBOL_DIV(3), .GAP_SYMBOLS(GAPS)) u1 (
        .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Letter(Letter), .Repeat(Repeat),
        .DotDashOut(dd1), .NewBitOut(nb1), .Busy(busy1), .Done(done1), .Error(err1));

    string mc [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // Expected cycle entries: {last bit of letter, Busy, DotDashOut, NewBitOut, Done, Error}
    logic [5:0] q0 [$];
    logic [5:0] q1 [$];
    logic [5:0] cur0 = 6'd0, cur1 = 6'd0;
    int lat [2];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string bits_of(input int l);
        string r = "";
        for (int i = 0; i < mc[l].len(); i++) begin
            if (i > 0) r = {r, "0"};
            r = {r, (mc[l].getc(i) == "-") ? "111" : "1"};
        end
        return r;
    endfunction

    task automatic push(input int d, input logic [5:0] e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic push_letter(input int d, input int l, input int sc);
        string r = bits_of(l);
        for (int b = 0; b < r.len(); b++)
            for (int c = 0; c < sc; c++)
                push(d, {b == r.len() - 1 && c == sc - 1, 1'b1, r.getc(b) == "1", c == 0, 2'b00});
    endtask

    task automatic push_gap(input int d, input int sc);
        for (int g = 0; g < GAPS; g++)
            for (int c = 0; c < sc; c++)
                push(d, {3'b010, c == 0, 2'b00});
    endtask

    task automatic step(input int d, input int sc);
        logic [5:0] p = (d == 0) ? cur0 : cur1;
        if (!p[4] && Start) begin
            if (Letter <= 5'd25) begin
                lat[d] = int'(Letter);
                push_letter(d, lat[d], sc);
            end else push(d, 6'b000001);
        end
        if (p[5]) begin
            if (REP && Repeat) begin
                push_gap(d, sc);
                push_letter(d, lat[d], sc);
            end else push(d, 6'b000010);
        end
        if (d == 0) cur0 = q0.size() > 0 ? q0.pop_front() : 6'd0;
        else cur1 = q1.size() > 0 ? q1.pop_front() : 6'd0;
    endtask

    always @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            q0.delete();
            q1.delete();
            cur0 = 6'd0;
            cur1 = 6'd0;
        end else begin
            step(0, 4);
            step(1, 1);
        end
    end

    always @(negedge ClockIn) begin
        check("cyc4", {busy4, dd4, nb4, done4, err4}, cur0[4:0]);
        check("cyc1", {busy1, dd1, nb1, done1, err1}, cur1[4:0]);
    end

    task automatic run(input int l, input int inj, output int busy, output int hi,
                       output longint nbm, output int done_at, output int dones, output int errs);
        busy = 0; hi = 0; nbm = 0; done_at = 0; dones = 0; errs = 0;
        @(negedge ClockIn);
        Start = 1'b1;
        Letter = 5'(l);
        for (int k = 1; k <= 60; k++) begin
            @(negedge ClockIn);
            if (k == 1) Start = 1'b0;
            if (k == inj) begin Start = 1'b1; Letter = 5'd0; end
            if (k == inj + 1) Start = 1'b0;
            busy += int'(busy4);
            hi += int'(dd4);
            if (nb4) nbm[k] = 1'b1;
            if (done4) begin dones++; done_at = k; end
            errs += int'(err4);
        end
    endtask

    initial begin
        int b, h, da, dn, er;
        longint m;
        check("model_A", longint'(bits_of(0) == "10111"), 1);
        check("model_Y", longint'(bits_of(24) == "1110101110111"), 1);
        repeat (2) @(negedge ClockIn);
        check("rst_state", {busy4, dd4, nb4, done4, err4, busy1, dd1, nb1, done1, err1}, 0);
        Reset = 1'b0;
        run(0, -1, b, h, m, da, dn, er);
        check("A_busy", b, 20); check("A_hi", h, 16); check("A_nb", m, 64'h22222);
        check("A_done_at", da, 21); check("A_dones", dn, 1);
        run(4, -1, b, h, m, da, dn, er);
        check("E_busy", b, 4); check("E_hi", h, 4); check("E_done_at", da, 5);
        run(24, -1, b, h, m, da, dn, er);
        check("Y_busy", b, 52); check("Y_hi", h, 40); check("Y_done_at", da, 53);
        run(27, -1, b, h, m, da, dn, er);
        check("bad_err", er, 1); check("bad_busy", b, 0); check("bad_hi", h, 0);
        check("bad_nb", m, 0); check("bad_dones", dn, 0);
        run(19, 5, b, h, m, da, dn, er);
        check("T_busy", b, 12); check("T_hi", h, 12); check("T_dones", dn, 1); check("T_done_at", da, 13);
        @(negedge ClockIn);
        Start = 1'b1;
        Letter = 5'd4;
        for (int k = 1; k <= 30; k++) begin
            @(negedge ClockIn);
            if (k == 5) check("hold_done", {busy4, done4}, 1);
            if (k == 6) begin check("hold_rebusy", {busy4, nb4}, 3); Start = 1'b0; end
        end
        @(negedge ClockIn);
        Start = 1'b1;
        Letter = 5'd1;
        @(negedge ClockIn);
        Start = 1'b0;
        repeat (5) @(negedge ClockIn);
        check("rst_pre", busy4, 1);
        @(posedge ClockIn);
        #2 Reset = 1'b1;
        #1 check("rst_async", {busy4, dd4, nb4, done4, err4, busy1, dd1, nb1, done1, err1}, 0);
        repeat (2) @(negedge ClockIn);
        Reset = 1'b0;
        run(1, -1, b, h, m, da, dn, er);
        check("B_busy", b, 36); check("B_hi", h, 24); check("B_dones", dn, 1); check("B_done_at", da, 37);
        Repeat = 1'b1;
        @(negedge ClockIn);
        Start = 1'b1;
        Letter = 5'd19;
        dn = 0; da = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge ClockIn);
            if (k == 1) Start = 1'b0;
            if (k == 20) check("rep_gap_busy", busy4, REP);
            if (k == 21) check("rep_gap_nb", nb4, REP);
            if (k == 30) Repeat = 1'b0;
            if (done4) begin dn++; da = k; end
        end
        check("rep_dones", dn, 1);
        check("rep_done_at", da, REP ? 37 : 13);
        repeat (3) @(negedge ClockIn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
